// File: rtl/rx_decode_scheduler.sv
// Receive-chain frame sequencer: waits out the rate-dependent decoder latency,
// then strobes desc_valid in a fixed window per block for n_blk blocks.
module rx_decode_scheduler #(
    parameter int LAT_R9  = 375,
    parameter int LAT_R5  = 279,
    parameter int LAT_DEF = 231,
    parameter int PERIOD  = 48,
    parameter int WIN     = 24,
    parameter int BLK_W   = 10
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [3:0]       rate,
    input  logic [BLK_W-1:0] n_blk,
    output logic             desc_valid,
    output logic             busy,
    output logic             done,
    output logic             start_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAT    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    localparam logic [8:0] THR_R9    = 9'(LAT_R9);
    localparam logic [8:0] THR_R5    = 9'(LAT_R5);
    localparam logic [8:0] THR_DEF   = 9'(LAT_DEF);
    localparam logic [5:0] PERIOD_M1 = 6'(PERIOD - 1);
    localparam logic [5:0] WIN_C     = 6'(WIN);

    logic [1:0]       state_q, state_d;
    logic [8:0]       lat_q, lat_d;
    logic [8:0]       thr_q, thr_d;
    logic [5:0]       phase_q, phase_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BLK_W-1:0] nblk_q, nblk_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [8:0]       thr_sel;
    logic [5:0]       phase_inc;

    always_comb begin
        case (rate)
            4'b1001: thr_sel = THR_R9;
            4'b0101: thr_sel = THR_R5;
            default: thr_sel = THR_DEF;
        endcase
    end

    assign phase_inc = phase_q + 6'd1;

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        thr_d   = thr_q;
        phase_d = phase_q;
        blk_d   = blk_q;
        nblk_d  = nblk_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort has priority: a coincident start is dropped silently
                if (start && !abort) begin
                    if (n_blk != '0) begin
                        thr_d   = thr_sel;
                        nblk_d  = n_blk;
                        lat_d   = '0;
                        busy_d  = 1'b1;
                        state_d = S_LAT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end

            S_LAT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    err_d = start;
                    if (lat_q == thr_q) begin
                        phase_d = '0;
                        blk_d   = '0;
                        valid_d = 1'b1;
                        state_d = S_STREAM;
                    end else begin
                        lat_d = lat_q + 9'd1;
                    end
                end
            end

            S_STREAM: begin
                if (abort) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end else begin
                    err_d = start;
                    if (phase_q == PERIOD_M1) begin
                        phase_d = '0;
                        blk_d   = blk_q + BLK_W'(1);
                        if (blk_q == nblk_q - BLK_W'(1)) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            valid_d = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                        end
                    end else begin
                        phase_d = phase_inc;
                        valid_d = (phase_inc < WIN_C);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            thr_q   <= '0;
            phase_q <= '0;
            blk_q   <= '0;
            nblk_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            thr_q   <= thr_d;
            phase_q <= phase_d;
            blk_q   <= blk_d;
            nblk_q  <= nblk_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign desc_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign start_err  = err_q;

endmodule

// File: tb/tb_rx_decode_scheduler.sv
// Scoreboard bench for rx_decode_scheduler: each accepted frame queues its
// expected first-valid cycle, valid count and done cycle, checked on done.
module tb_rx_decode_scheduler;

    localparam int PERIOD = 48;
    localparam int WIN    = 24;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] rate = 4'd0;
    logic [9:0] n_blk = 10'd0;
    logic       desc_valid, busy, done, start_err;

    rx_decode_scheduler dut (
        .Clk        (Clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .rate       (rate),
        .n_blk      (n_blk),
        .desc_valid (desc_valid),
        .busy       (busy),
        .done       (done),
        .start_err  (start_err)
    );

    always #5 Clk = ~Clk;

    // number of rising edges seen so far; stable when sampled at negedge
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int e0;
        int first_dv;
        int dv_cnt;
        int done_at;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int thr_of(input logic [3:0] r);
        case (r)
            4'b1001: return 375;
            4'b0101: return 279;
            default: return 231;
        endcase
    endfunction

    // monitor: accumulate the valid pattern of the running frame, score it on done
    int   m_first = -1;
    int   m_cnt   = 0;
    exp_t m_e;
    always @(negedge Clk) begin
        if (!busy && desc_valid) check("valid_outside_frame", 1, 0);
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check("done_cycle", cyc, m_e.done_at);
                check("first_valid", m_first, m_e.first_dv);
                check("valid_count", m_cnt, m_e.dv_cnt);
                $display("frame e0=%0d done at %0d first_valid=%0d valid_cycles=%0d",
                         m_e.e0, cyc, m_first, m_cnt);
            end
            m_first = -1;
            m_cnt   = 0;
        end else if (!busy) begin
            m_first = -1;
            m_cnt   = 0;
        end else if (desc_valid) begin
            if (m_first < 0) m_first = cyc;
            m_cnt++;
        end
    end

    // called at a negedge; start is sampled at the next rising edge (e0)
    task automatic launch(input logic [3:0] r, input int nb, input bit expect_done);
        exp_t e;
        start = 1'b1;
        rate  = r;
        n_blk = nb[9:0];
        e.e0  = cyc + 1;
        if (nb == 0) begin
            e.first_dv = -1;
            e.dv_cnt   = 0;
            e.done_at  = e.e0;
        end else begin
            e.first_dv = e.e0 + thr_of(r) + 1;
            e.dv_cnt   = nb * WIN;
            e.done_at  = e.e0 + thr_of(r) + 1 + nb * PERIOD;
        end
        if (expect_done) sb.push_back(e);
        $display("start rate=%b n_blk=%0d e0=%0d expect_done=%0d", r, nb, e.e0, expect_done);
        @(negedge Clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge Clk);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge Clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int k;
        int d;

        repeat (3) @(negedge Clk);
        check("rst_valid", desc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_start_err", start_err, 0);
        reset = 1'b1;
        @(negedge Clk);

        // rate 1001, two blocks, with a stray start mid-latency
        check("busy_before_start", busy, 0);
        launch(4'b1001, 2, 1'b1);
        e0 = cyc;
        check("busy_after_start", busy, 1);
        wait_until(e0 + 99);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check("start_err_pulse", start_err, 1);
        @(negedge Clk);
        check("start_err_clear", start_err, 0);
        check("busy_kept", busy, 1);
        wait_drain(600);
        check("busy_after_done", busy, 0);

        // rate 0101 one block, then rate 0011 started in the done cycle
        launch(4'b0101, 1, 1'b1);
        k = 0;
        while (!done && k < 500) begin
            @(negedge Clk);
            k++;
        end
        check("b2b_done_seen", done, 1);
        d = cyc;
        launch(4'b0011, 1, 1'b1);
        check("b2b_cycle", cyc, d + 1);
        check("b2b_busy", busy, 1);
        wait_drain(400);

        // zero-block frame completes immediately
        @(negedge Clk);
        launch(4'b1001, 0, 1'b1);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_valid", desc_valid, 0);
        @(negedge Clk);
        check("zero_done_clear", done, 0);
        wait_drain(10);

        // abort in the middle of the first valid window
        launch(4'b1001, 2, 1'b0);
        e0 = cyc;
        wait_until(e0 + 389);
        check("valid_before_abort", desc_valid, 1);
        abort = 1'b1;
        @(negedge Clk);
        abort = 1'b0;
        check("abort_valid", desc_valid, 0);
        check("abort_busy", busy, 0);
        repeat (150) @(negedge Clk);
        launch(4'b1001, 1, 1'b1);
        wait_drain(500);

        // asynchronous reset mid-stream
        launch(4'b0101, 2, 1'b0);
        e0 = cyc;
        rate = 4'b1001;
        wait_until(e0 + 285);
        check("valid_before_reset", desc_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("areset_valid", desc_valid, 0);
        check("areset_busy", busy, 0);
        check("areset_done", done, 0);
        check("areset_start_err", start_err, 0);
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("idle_after_reset", busy, 0);

        // rate/n_blk changes while busy must not alter the latched frame
        launch(4'b0101, 1, 1'b1);
        rate  = 4'b1001;
        n_blk = 10'd5;
        wait_drain(500);

        repeat (5) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
